// File: rtl/flappy_pkg.sv
// Shared types and default sizes for the sprite ROM arbiter and its tag pipeline.
package flappy_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  localparam int NUM_REQ_DEF   = 3;
  localparam int ADDR_W_DEF    = 12;
  localparam int DATA_W_DEF    = 24;
  localparam int ROM_LAT_DEF   = 2;
  localparam int BURST_MAX_DEF = 8;
  localparam int STAT_W        = 16;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// Fixed-latency delay line carrying (valid, requester index) alongside ROM reads.
module arb_tag_pipe #(
  parameter int ROM_LAT = 2,
  parameter int IDX_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  logic [ROM_LAT-1:0] r_valid;
  logic [IDX_W-1:0]   r_idx [ROM_LAT];

  // NOTE: only r_valid needs reset for correctness; r_idx is cleared as well so o_idx never carries X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < ROM_LAT; i++) r_idx[i] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_idx[0]   <= i_idx;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_idx[i]   <= r_idx[i-1];
      end
    end
  end

  assign o_valid = r_valid[ROM_LAT-1];
  assign o_idx   = r_idx[ROM_LAT-1];

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin burst arbiter sharing one sprite ROM between requesters, with tagged returns.
// Optional SPRITE_ARB_STATS_EN adds per-requester saturating stall counters.
module sprite_rom_arbiter
  import flappy_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ROM_LAT   = ROM_LAT_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_flat,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rom_rd,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data
`ifdef SPRITE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] stall_count_flat
`endif
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_MAX + 1);

  arb_state_e       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_rr_ptr, w_rr_nxt;
  logic [IDX_W-1:0] r_owner, w_owner_nxt;
  logic [CNT_W-1:0] r_burst_cnt, w_cnt_nxt;

  logic [IDX_W-1:0] w_owner_inc, w_from, w_pick, w_gnt_idx;
  logic             w_found, w_gnt_any;
  logic             w_tag_valid;
  logic [IDX_W-1:0] w_tag_idx;

  assign w_owner_inc = (int'(r_owner) == NUM_REQ - 1) ? '0 : r_owner + IDX_W'(1);
  assign w_from      = (r_state == ST_BURST) ? w_owner_inc : r_rr_ptr;

  // Round-robin search: walk downward so the smallest offset from w_from wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int j;
      j = int'(w_from) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'(j);
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_burst_cnt;
    w_gnt_any   = 1'b0;
    w_gnt_idx   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_gnt_any   = 1'b1;
          w_gnt_idx   = w_pick;
          w_state_nxt = ST_BURST;
          w_owner_nxt = w_pick;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      ST_BURST: begin
        if (req[r_owner] && (r_burst_cnt < CNT_W'(BURST_MAX))) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = r_owner;
          w_cnt_nxt = r_burst_cnt + CNT_W'(1);
        end else begin
          w_rr_nxt = w_owner_inc;
          if (w_found) begin
            w_gnt_any   = 1'b1;
            w_gnt_idx   = w_pick;
            w_owner_nxt = w_pick;
            w_cnt_nxt   = CNT_W'(1);
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_owner     <= w_owner_nxt;
      r_burst_cnt <= w_cnt_nxt;
    end
  end

  // Grant is gated by rst so the ROM port is quiet for the whole reset assertion.
  assign gnt      = (w_gnt_any && !rst) ? (NUM_REQ'(1) << w_gnt_idx) : '0;
  assign rom_rd   = |(req & gnt);
  assign rom_addr = rom_rd ? addr_flat[int'(w_gnt_idx)*ADDR_W +: ADDR_W] : '0;

  arb_tag_pipe #(
    .ROM_LAT (ROM_LAT),
    .IDX_W   (IDX_W)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (rom_rd),
    .i_idx   (w_gnt_idx),
    .o_valid (w_tag_valid),
    .o_idx   (w_tag_idx)
  );

  assign rd_valid = w_tag_valid ? (NUM_REQ'(1) << w_tag_idx) : '0;
  assign rd_data  = w_tag_valid ? rom_data : '0;

`ifdef SPRITE_ARB_STATS_EN
  logic [STAT_W-1:0] r_stall [NUM_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) r_stall[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (req[i] && !gnt[i] && (r_stall[i] != '1)) r_stall[i] <= r_stall[i] + STAT_W'(1);
    end
  end

  always_comb begin
    stall_count_flat = '0;
    for (int i = 0; i < NUM_REQ; i++) stall_count_flat[i*STAT_W +: STAT_W] = r_stall[i];
  end
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: vector table plus reset, round-robin, burst and stats sequences.
`timescale 1ns/1ps
module tb_sprite_rom_arbiter;

  localparam logic [11:0] A0 = 12'h100;
  localparam logic [11:0] A1 = 12'h211;
  localparam logic [11:0] A2 = 12'h0A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = 3'b000;
  logic [35:0] addr_flat;
  logic [2:0]  gnt, rd_valid;
  logic        rom_rd;
  logic [11:0] rom_addr;
  logic [23:0] rom_data, rd_data;

  logic [2:0]  rr_gnt, rr_rd_valid;
  logic        rr_rom_rd;
  logic [11:0] rr_rom_addr;
  logic [23:0] rr_rd_data;

`ifdef SPRITE_ARB_STATS_EN
  logic [47:0] stall_count_flat, rr_stall_count_flat;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  assign addr_flat = {A2, A1, A0};

  function automatic logic [23:0] rom_fn(input logic [11:0] a);
    return {a ^ 12'h5A5, a};
  endfunction

  // Two-cycle ROM model driven from the main DUT's address port.
  logic [23:0] rom_q0 = '0, rom_q1 = '0;
  always @(posedge clk) begin
    rom_q0 <= rom_fn(rom_addr);
    rom_q1 <= rom_q0;
  end
  assign rom_data = rom_q1;

  sprite_rom_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .addr_flat (addr_flat),
    .gnt       (gnt),
    .rom_rd    (rom_rd),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data)
`ifdef SPRITE_ARB_STATS_EN
    ,
    .stall_count_flat (stall_count_flat)
`endif
  );

  sprite_rom_arbiter #(.BURST_MAX(1)) dut_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .addr_flat (addr_flat),
    .gnt       (rr_gnt),
    .rom_rd    (rr_rom_rd),
    .rom_addr  (rr_rom_addr),
    .rom_data  (rom_data),
    .rd_valid  (rr_rd_valid),
    .rd_data   (rr_rd_data)
`ifdef SPRITE_ARB_STATS_EN
    ,
    .stall_count_flat (rr_stall_count_flat)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  gnt;
    logic        rd;
    logic [11:0] raddr;
    logic [2:0]  rv;
    logic [23:0] rdata;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{3'b000, 3'b000, 1'b0, 12'h000, 3'b000, 24'h0};
    vecs[1]  = '{3'b100, 3'b100, 1'b1, A2,      3'b000, 24'h0};
    vecs[2]  = '{3'b000, 3'b000, 1'b0, 12'h000, 3'b000, 24'h0};
    vecs[3]  = '{3'b000, 3'b000, 1'b0, 12'h000, 3'b100, rom_fn(A2)};
    vecs[4]  = '{3'b010, 3'b010, 1'b1, A1,      3'b000, 24'h0};
    vecs[5]  = '{3'b011, 3'b010, 1'b1, A1,      3'b000, 24'h0};
    vecs[6]  = '{3'b001, 3'b001, 1'b1, A0,      3'b010, rom_fn(A1)};
    vecs[7]  = '{3'b000, 3'b000, 1'b0, 12'h000, 3'b010, rom_fn(A1)};
    vecs[8]  = '{3'b000, 3'b000, 1'b0, 12'h000, 3'b001, rom_fn(A0)};
    vecs[9]  = '{3'b101, 3'b100, 1'b1, A2,      3'b000, 24'h0};
    vecs[10] = '{3'b000, 3'b000, 1'b0, 12'h000, 3'b000, 24'h0};
    vecs[11] = '{3'b000, 3'b000, 1'b0, 12'h000, 3'b100, rom_fn(A2)};

    // Outputs stay quiet while reset is held, even with every request raised.
    req = 3'b111;
    @(negedge clk);
    check("rst gnt", 32'(gnt), 32'h0);
    check("rst rom_rd", 32'(rom_rd), 32'h0);
    check("rst rom_addr", 32'(rom_addr), 32'h0);
    check("rst rd_valid", 32'(rd_valid), 32'h0);
    check("rst rd_data", 32'(rd_data), 32'h0);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      req = vecs[i].req;
      @(negedge clk);
      check($sformatf("vec%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      check($sformatf("vec%0d rom_rd", i), 32'(rom_rd), 32'(vecs[i].rd));
      check($sformatf("vec%0d rom_addr", i), 32'(rom_addr), 32'(vecs[i].raddr));
      check($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].rv));
      check($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(vecs[i].rdata));
      next_cycle();
    end

    // Sole requester past the burst cap keeps its grant with no bubble.
    do_reset();
    req = 3'b010;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("cap%0d gnt", i), 32'(gnt), 32'h2);
      check($sformatf("cap%0d rom_rd", i), 32'(rom_rd), 32'h1);
      next_cycle();
    end

    // Burst of 8 to requester 0, then handoff to 2 in the next cycle.
    do_reset();
    req = 3'b101;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check($sformatf("handoff%0d gnt", i), 32'(gnt), (i < 8) ? 32'h1 : 32'h4);
      next_cycle();
    end

    // Round-robin with BURST_MAX=1 rotates every cycle without idle gaps.
    do_reset();
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rr%0d gnt", i), 32'(rr_gnt), 32'(3'b001 << (i % 3)));
      check($sformatf("rr%0d rom_rd", i), 32'(rr_rom_rd), 32'h1);
      next_cycle();
    end

    // Reset mid-burst with two reads in flight.
    do_reset();
    req = 3'b001;
    repeat (2) begin
      @(negedge clk);
      check("pre-rst gnt", 32'(gnt), 32'h1);
      next_cycle();
    end
    rst = 1'b1;
    #1;
    check("midrst gnt", 32'(gnt), 32'h0);
    check("midrst rom_rd", 32'(rom_rd), 32'h0);
    check("midrst rom_addr", 32'(rom_addr), 32'h0);
    check("midrst rd_valid", 32'(rd_valid), 32'h0);
    check("midrst rd_data", 32'(rd_data), 32'h0);
    next_cycle();
    rst = 1'b0;
    req = 3'b000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("postrst%0d rd_valid", i), 32'(rd_valid), 32'h0);
      check($sformatf("postrst%0d rd_data", i), 32'(rd_data), 32'h0);
      next_cycle();
    end

`ifdef SPRITE_ARB_STATS_EN
    // Requester 1 waits 5 cycles behind requester 0's burst.
    do_reset();
    req = 3'b001;
    next_cycle();
    req = 3'b011;
    repeat (5) next_cycle();
    req = 3'b010;
    @(negedge clk);
    check("stats handoff gnt", 32'(gnt), 32'h2);
    next_cycle();
    req = 3'b000;
    @(negedge clk);
    check("stall1", 32'(stall_count_flat[16 +: 16]), 32'd5);
    check("stall0", 32'(stall_count_flat[0 +: 16]), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: number of sprite requesters (0=bird, 1=pipes, 2=score digits).
REQ-002 SHALL have parameter ADDR_W, default 12: sprite ROM address width.
REQ-003 SHALL have parameter DATA_W, default 24: ROM word width, one RGB pixel.
REQ-004 SHALL have parameter ROM_LAT, default 2: fixed ROM read latency in cycles, range 1..4.
REQ-005 SHALL have parameter BURST_MAX, default 8: maximum consecutive grants to one requester.
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port req  input  NUM_REQ  per-requester read request, level.
REQ-009 SHALL have port addr_flat  input  NUM_REQ*ADDR_W  request addresses; requester i at bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port gnt  output  NUM_REQ  one-hot grant; a request is accepted in a cycle where req[i] and gnt[i] are both high.
REQ-011 SHALL have port rom_rd  output  1  ROM read strobe.
REQ-012 SHALL have port rom_addr  output  ADDR_W  ROM address.
REQ-013 SHALL have port rom_data  input  DATA_W  ROM read data, valid ROM_LAT cycles after rom_rd.
REQ-014 SHALL have port rd_valid  output  NUM_REQ  one-hot return strobe.
REQ-015 SHALL have port rd_data  output  DATA_W  returned pixel, qualified by rd_valid.

Function
REQ-016 SHALL grant at most one requester per cycle; gnt is combinational from req and registered arbiter state.
REQ-017 SHALL drive rom_rd = |(req & gnt) and rom_addr = addr of the granted requester in the same cycle; rom_addr = 0 when rom_rd is low.
REQ-018 SHALL use FSM states IDLE and BURST; IDLE: grant the first requesting index at or after rr_ptr (round-robin), go to BURST with owner = that index, burst_cnt = 1.
REQ-019 SHALL in BURST keep gnt on owner while req[owner] high and burst_cnt < BURST_MAX, incrementing burst_cnt per accepted beat.
REQ-020 SHALL leave BURST when req[owner] drops or burst_cnt = BURST_MAX: set rr_ptr = owner+1 (wrap NUM_REQ-1 -> 0); if other requests pending, grant next round-robin winner in that same cycle (no idle bubble), else go to IDLE.
REQ-021 SHALL re-grant a sole requester after a BURST_MAX expiry with no bubble, burst_cnt restarting at 1.
REQ-022 SHALL carry a ROM_LAT-deep tag pipeline (valid + index) so returned data pulses rd_valid[index] exactly ROM_LAT cycles after acceptance, rd_data = rom_data that cycle.
REQ-023 SHALL sustain one accepted read per cycle; returns are in acceptance order.
REQ-024 SHALL drive rd_data = 0 when no rd_valid bit is high.
REQ-025 SHALL deliver the return for an accepted beat even if the requester deasserts req before it arrives.

Reset
REQ-026 SHALL on rst asynchronously clear: state = IDLE, rr_ptr = 0, owner = 0, burst_cnt = 0, tag pipeline invalid; gnt, rom_rd, rom_addr, rd_valid, rd_data all 0.
REQ-027 SHALL discard in-flight reads on reset mid-operation; no rd_valid for them after rst release.

Configuration
REQ-028 SHALL, when SPRITE_ARB_STATS_EN is defined, add output stall_count_flat NUM_REQ*16: per requester, count of cycles with req[i] high and gnt[i] low, saturating at 16'hFFFF, cleared by rst.
REQ-029 SHALL, without SPRITE_ARB_STATS_EN, omit the port and counters; arbitration behaviour is identical.

Structure
REQ-030 SHALL place the FSM state encoding (IDLE, BURST) and default widths in shared package flappy_pkg.
REQ-031 SHALL implement the tag delay line as sub-module arb_tag_pipe (parameters ROM_LAT, index width).

Verification
REQ-032 SHALL check reset: rst pulse mid-burst with 2 reads in flight -> all outputs 0 immediately, no rd_valid afterwards.
REQ-033 SHALL check round-robin: req=3'b111 held, BURST_MAX=1 -> gnt sequence 001,010,100,001; no idle cycles.
REQ-034 SHALL check burst cap: only req[1] high for 20 cycles, BURST_MAX=8 -> 20 consecutive grants to 1, rom_rd high every cycle.
REQ-035 SHALL check burst handoff: req[0] and req[2] high, BURST_MAX=8 -> 8 grants to 0 then grant to 2 next cycle.
REQ-036 SHALL check return routing: accept req[2] addr 0x0A5, ROM_LAT=2 -> rd_valid=3'b100 two cycles later with rd_data = ROM[0x0A5].
REQ-037 SHALL check stats (with SPRITE_ARB_STATS_EN): req[1] blocked 5 cycles by req[0] burst -> stall_count for 1 = 5.
